// File: rtl/ibex_irq_aggregator_if.sv
// rtl/ibex_irq_aggregator_if.sv - word-addressed register port bundle for ibex_irq_aggregator
//
// Signals:
//   cfg_req     request, single cycle (master -> slave)
//   cfg_we      1 = write, 0 = read
//   cfg_addr    word index
//   cfg_wdata   write data
//   cfg_rvalid  response valid, one cycle after cfg_req (slave -> master)
//   cfg_rdata   read data, 0 for writes
interface ibex_irq_aggregator_if;
    logic        cfg_req;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_req, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rvalid, cfg_rdata
    );

    modport slave (
        input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
        output cfg_rvalid, cfg_rdata
    );
endinterface

// File: rtl/ibex_irq_aggregator.sv
// rtl/ibex_irq_aggregator.sv - interrupt source aggregator driving the core irq inputs
//
// Collects 18 peripheral interrupt lines plus an NMI, latches edge sources as
// pending, lets level sources follow their line, masks with a software enable
// and drives registered levels into the core.
//
// Optional feature macro: IRQ_AGG_SYNC_EN
//   defined   : src_i / nmi_i pass through a SyncStages-deep synchroniser
//   undefined : sources are taken as synchronous to clk_i
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   src_i[17:0]       raw sources: [17] software, [16] timer, [15] external, [14:0] fast
//   nmi_i             raw NMI source, always edge-triggered
//   cfg               register port (slave modport)
//   irq_*_o           registered interrupt levels to the core
//
// Register map (word index):
//   0 ENABLE  RW  bits[17:0]
//   1 PENDING R / W1C on edge bits only
//   2 STATUS  RO  synchronised sources
//   3 NMI     bit0 = nmi pending, W1C
module ibex_irq_aggregator #(
    parameter logic [17:0] EdgeMask   = 18'h0,
    parameter int unsigned SyncStages = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [17:0]           src_i,
    input  logic                  nmi_i,
    ibex_irq_aggregator_if.slave  cfg,
    output logic                  irq_software_o,
    output logic                  irq_timer_o,
    output logic                  irq_external_o,
    output logic [14:0]           irq_fast_o,
    output logic                  irq_nm_o
);

    logic [17:0] src_s;
    logic        nmi_s;

`ifdef IRQ_AGG_SYNC_EN
    // NMI travels in bit 18 alongside the regular sources.
    logic [SyncStages-1:0][18:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], {nmi_i, src_i}};
        end
    end

    assign {nmi_s, src_s} = sync_q[SyncStages-1];
`else
    assign src_s = src_i;
    assign nmi_s = nmi_i;
`endif

    logic [17:0] src_prev_q;
    logic [17:0] pending_q, pending_d;
    logic [17:0] enable_q, enable_d;
    logic [17:0] irq_q;
    logic        nmi_prev_q;
    logic        nmi_pending_q, nmi_pending_d;
    logic        irq_nm_q;
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_en;
    logic [17:0] rise;
    logic [17:0] pend_clr;
    logic        nmi_clr;

    logic        unused_wdata;
    assign unused_wdata = ^cfg.cfg_wdata[31:18];

    always_comb begin
        wr_en    = cfg.cfg_req & cfg.cfg_we;
        rise     = src_s & ~src_prev_q;
        pend_clr = '0;
        nmi_clr  = 1'b0;
        enable_d = enable_q;

        if (wr_en) begin
            case (cfg.cfg_addr)
                2'd0:    enable_d = cfg.cfg_wdata[17:0];
                2'd1:    pend_clr = cfg.cfg_wdata[17:0] & EdgeMask;
                2'd3:    nmi_clr  = cfg.cfg_wdata[0];
                default: ;
            endcase
        end

        // Clear is applied before the set term so a coincident rise wins.
        pending_d     = (EdgeMask & ((pending_q & ~pend_clr) | rise))
                      | (~EdgeMask & src_s);
        nmi_pending_d = (nmi_pending_q & ~nmi_clr) | (nmi_s & ~nmi_prev_q);

        // Reads sample the state before any write in the same cycle lands.
        rdata_d = '0;
        if (cfg.cfg_req && !cfg.cfg_we) begin
            case (cfg.cfg_addr)
                2'd0:    rdata_d = {14'b0, enable_q};
                2'd1:    rdata_d = {14'b0, pending_q};
                2'd2:    rdata_d = {14'b0, src_s};
                default: rdata_d = {31'b0, nmi_pending_q};
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_prev_q    <= '0;
            pending_q     <= '0;
            enable_q      <= '0;
            irq_q         <= '0;
            nmi_prev_q    <= 1'b0;
            nmi_pending_q <= 1'b0;
            irq_nm_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            src_prev_q    <= src_s;
            pending_q     <= pending_d;
            enable_q      <= enable_d;
            irq_q         <= pending_q & enable_q;
            nmi_prev_q    <= nmi_s;
            nmi_pending_q <= nmi_pending_d;
            irq_nm_q      <= nmi_pending_q;
            rvalid_q      <= cfg.cfg_req;
            rdata_q       <= rdata_d;
        end
    end

    assign irq_software_o = irq_q[17];
    assign irq_timer_o    = irq_q[16];
    assign irq_external_o = irq_q[15];
    assign irq_fast_o     = irq_q[14:0];
    assign irq_nm_o       = irq_nm_q;
    assign cfg.cfg_rvalid = rvalid_q;
    assign cfg.cfg_rdata  = rdata_q;

endmodule

// File: tb/tb_ibex_irq_aggregator.sv
// tb/tb_ibex_irq_aggregator.sv - self-checking bench for ibex_irq_aggregator
module tb_ibex_irq_aggregator;

`ifdef IRQ_AGG_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = SYNC + 2;
    localparam logic [17:0] EMASK = 18'h000FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] src;
    logic        nmi;
    logic        irq_software, irq_timer, irq_external, irq_nm;
    logic [14:0] irq_fast;

    int checks = 0;
    int errors = 0;

    ibex_irq_aggregator_if cfg_if ();

    ibex_irq_aggregator #(.EdgeMask(EMASK), .SyncStages(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .src_i          (src),
        .nmi_i          (nmi),
        .cfg            (cfg_if.slave),
        .irq_software_o (irq_software),
        .irq_timer_o    (irq_timer),
        .irq_external_o (irq_external),
        .irq_fast_o     (irq_fast),
        .irq_nm_o       (irq_nm)
    );

    always #5 clk = ~clk;

    wire [17:0] irq_vec = {irq_software, irq_timer, irq_external, irq_fast};

    // Reference model: per-source rules with an explicit sample history for the synchroniser.
    logic [18:0] m_hist [0:3];
    logic [18:0] m_prev;
    logic [17:0] m_pend, m_en, m_irq;
    logic        m_nmi, m_nm, m_rvalid;
    logic [31:0] m_rdata;

    always @(posedge clk or negedge rst_n) begin : model
        logic [18:0] s;
        logic [17:0] n_pend;
        logic        n_nmi;
        logic [31:0] n_rdata;
        logic        rd, wr;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) m_hist[k] <= '0;
            m_prev <= '0; m_pend <= '0; m_en <= '0; m_irq <= '0;
            m_nmi <= 1'b0; m_nm <= 1'b0; m_rvalid <= 1'b0; m_rdata <= '0;
        end else begin
            s  = (SYNC == 0) ? {nmi, src} : m_hist[(SYNC == 0) ? 0 : SYNC - 1];
            rd = cfg_if.cfg_req && !cfg_if.cfg_we;
            wr = cfg_if.cfg_req && cfg_if.cfg_we;
            n_rdata = 32'h0;
            if (rd) begin
                case (cfg_if.cfg_addr)
                    2'd0: n_rdata = 32'(m_en);
                    2'd1: n_rdata = 32'(m_pend);
                    2'd2: n_rdata = 32'(s[17:0]);
                    default: n_rdata = 32'(m_nmi);
                endcase
            end
            n_pend = m_pend;
            for (int i = 0; i < 18; i++) begin
                if (EMASK[i]) begin
                    if (s[i] && !m_prev[i]) n_pend[i] = 1'b1;
                    else if (wr && cfg_if.cfg_addr == 2'd1 && cfg_if.cfg_wdata[i]) n_pend[i] = 1'b0;
                end else begin
                    n_pend[i] = s[i];
                end
            end
            n_nmi = m_nmi;
            if (s[18] && !m_prev[18]) n_nmi = 1'b1;
            else if (wr && cfg_if.cfg_addr == 2'd3 && cfg_if.cfg_wdata[0]) n_nmi = 1'b0;
            m_irq    <= m_pend & m_en;
            m_nm     <= m_nmi;
            m_rvalid <= cfg_if.cfg_req;
            m_rdata  <= n_rdata;
            m_pend   <= n_pend;
            m_nmi    <= n_nmi;
            if (wr && cfg_if.cfg_addr == 2'd0) m_en <= cfg_if.cfg_wdata[17:0];
            m_prev <= s;
            for (int k = 3; k > 0; k--) m_hist[k] <= m_hist[k-1];
            m_hist[0] <= {nmi, src};
        end
    end

    // Bus helpers: called just after a negedge, return just after the next negedge.
    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_if.cfg_req = 1'b1; cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = a; cfg_if.cfg_wdata = d;
        @(negedge clk);
        cfg_if.cfg_req = 1'b0; cfg_if.cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_if.cfg_req = 1'b1; cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = a;
        @(negedge clk);
        d = cfg_if.cfg_rdata;
        cfg_if.cfg_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (irq_vec !== 18'h0) begin errors++; $display("FAIL reset_irq got %h exp 0", irq_vec); end
        checks++; if (irq_nm !== 1'b0) begin errors++; $display("FAIL reset_nm got %b exp 0", irq_nm); end
        checks++; if (cfg_if.cfg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", cfg_if.cfg_rvalid); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cfg_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_enable got %h exp 0", d); end
        cfg_read(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", d); end
    endtask

    task automatic test_level_latency();
        cfg_write(2'd0, 32'h3FFFF);
        src[16] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            checks++;
            if (irq_timer !== (k >= LAT)) begin errors++; $display("FAIL level_rise edge %0d got %b exp %b", k, irq_timer, k >= LAT); end
        end
        src[16] = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            checks++;
            if (irq_timer !== (k < LAT)) begin errors++; $display("FAIL level_fall edge %0d got %b exp %b", k, irq_timer, k < LAT); end
        end
    endtask

    task automatic test_edge_pending();
        logic [31:0] d;
        cfg_write(2'd0, 32'h0);
        src[0] = 1'b1;
        @(negedge clk);
        src[0] = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        checks++; if (irq_fast !== 15'h0) begin errors++; $display("FAIL edge_masked got %h exp 0", irq_fast); end
        cfg_read(2'd1, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_pending got %h exp 1", d); end
        cfg_write(2'd0, 32'h1);
        checks++; if (irq_fast[0] !== 1'b0) begin errors++; $display("FAIL enable_same_edge got %b exp 0", irq_fast[0]); end
        @(negedge clk);
        checks++; if (irq_fast[0] !== 1'b1) begin errors++; $display("FAIL enable_next_edge got %b exp 1", irq_fast[0]); end
        cfg_write(2'd1, 32'h1);
        checks++; if (irq_fast[0] !== 1'b1) begin errors++; $display("FAIL w1c_same_edge got %b exp 1", irq_fast[0]); end
        @(negedge clk);
        checks++; if (irq_fast[0] !== 1'b0) begin errors++; $display("FAIL w1c_next_edge got %b exp 0", irq_fast[0]); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        cfg_read(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL setwins_pre got %h exp 0", d); end
        src[0] = 1'b1;
        repeat (SYNC) @(negedge clk);
        cfg_write(2'd1, 32'h1);
        repeat (LAT) @(negedge clk);
        cfg_read(2'd1, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL setwins_pending got %h exp 1", d); end
        checks++; if (irq_fast[0] !== 1'b1) begin errors++; $display("FAIL setwins_irq got %b exp 1", irq_fast[0]); end
        src[0] = 1'b0;
        cfg_write(2'd1, 32'h1);
        repeat (LAT) @(negedge clk);
    endtask

    task automatic test_nmi();
        logic [31:0] d;
        cfg_write(2'd0, 32'h0);
        nmi = 1'b1;
        @(negedge clk);
        nmi = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        checks++; if (irq_nm !== 1'b1) begin errors++; $display("FAIL nmi_out got %b exp 1", irq_nm); end
        cfg_read(2'd3, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL nmi_reg got %h exp 1", d); end
        cfg_write(2'd3, 32'h1);
        checks++; if (irq_nm !== 1'b1) begin errors++; $display("FAIL nmi_clr_same got %b exp 1", irq_nm); end
        @(negedge clk);
        checks++; if (irq_nm !== 1'b0) begin errors++; $display("FAIL nmi_clr_next got %b exp 0", irq_nm); end
        cfg_read(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL nmi_reg_clr got %h exp 0", d); end
    endtask

    task automatic test_status();
        logic [31:0] d;
        src = 18'h2A5A5;
        repeat (LAT + 1) @(negedge clk);
        checks++; if (cfg_if.cfg_rvalid !== 1'b0) begin errors++; $display("FAIL status_rvalid_pre got %b exp 0", cfg_if.cfg_rvalid); end
        cfg_if.cfg_req = 1'b1; cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = 2'd2;
        @(negedge clk);
        cfg_if.cfg_req = 1'b0;
        checks++; if (cfg_if.cfg_rvalid !== 1'b1) begin errors++; $display("FAIL status_rvalid got %b exp 1", cfg_if.cfg_rvalid); end
        checks++; if (cfg_if.cfg_rdata !== 32'h2A5A5) begin errors++; $display("FAIL status_data got %h exp 2a5a5", cfg_if.cfg_rdata); end
        @(negedge clk);
        checks++; if (cfg_if.cfg_rvalid !== 1'b0) begin errors++; $display("FAIL status_rvalid_post got %b exp 0", cfg_if.cfg_rvalid); end
        cfg_read(2'd1, d);
        checks++; if (d !== 32'h2A5A5) begin errors++; $display("FAIL status_pending got %h exp 2a5a5", d); end
        cfg_write(2'd1, 32'h3FF00);
        cfg_read(2'd1, d);
        checks++; if (d !== 32'h2A5A5) begin errors++; $display("FAIL level_w1c_ignored got %h exp 2a5a5", d); end
        src = 18'h0;
        cfg_write(2'd1, 32'hFF);
        repeat (LAT) @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        cfg_write(2'd0, 32'h3FFFF);
        src = 18'h3FFFF; nmi = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        checks++; if (irq_vec !== 18'h3FFFF) begin errors++; $display("FAIL pre_reset_irq got %h exp 3ffff", irq_vec); end
        checks++; if (irq_nm !== 1'b1) begin errors++; $display("FAIL pre_reset_nm got %b exp 1", irq_nm); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (irq_vec !== 18'h0) begin errors++; $display("FAIL async_reset_irq got %h exp 0", irq_vec); end
        checks++; if (irq_nm !== 1'b0) begin errors++; $display("FAIL async_reset_nm got %b exp 0", irq_nm); end
        src = 18'h1; nmi = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        repeat (LAT + 1) @(negedge clk);
        cfg_read(2'd1, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL release_pending got %h exp 1", d); end
        cfg_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL release_enable got %h exp 0", d); end
        cfg_write(2'd1, 32'h1);
        repeat (LAT + 2) @(negedge clk);
        cfg_read(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL release_once got %h exp 0", d); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++; if (irq_vec !== m_irq) begin errors++; $display("FAIL rand_irq cyc %0d got %h exp %h", c, irq_vec, m_irq); end
            checks++; if (irq_nm !== m_nm) begin errors++; $display("FAIL rand_nm cyc %0d got %b exp %b", c, irq_nm, m_nm); end
            checks++; if (cfg_if.cfg_rvalid !== m_rvalid) begin errors++; $display("FAIL rand_rvalid cyc %0d got %b exp %b", c, cfg_if.cfg_rvalid, m_rvalid); end
            checks++; if (cfg_if.cfg_rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata cyc %0d got %h exp %h", c, cfg_if.cfg_rdata, m_rdata); end
            if ($urandom_range(0, 3) == 0) src = 18'($urandom);
            nmi = ($urandom_range(0, 5) == 0);
            cfg_if.cfg_req   = ($urandom_range(0, 1) == 1);
            cfg_if.cfg_we    = ($urandom_range(0, 1) == 1);
            cfg_if.cfg_addr  = 2'($urandom_range(0, 3));
            cfg_if.cfg_wdata = $urandom;
        end
        @(negedge clk);
        cfg_if.cfg_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; src = '0; nmi = 1'b0;
        cfg_if.cfg_req = 1'b0; cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_wdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_level_latency();
        test_edge_pending();
        test_set_wins();
        test_nmi();
        test_status();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
